// File: rtl/alu_pkg.sv
// Shared definitions for the ALU issue stage: ALU control codes, MIPS
// opcode/funct values, the output FSM states, the buffered op record and
// the instruction decode helper.
package alu_pkg;

  // ALU control codes understood by the downstream ALU
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADDU = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_NOR  = 4'b0100;
  localparam logic [3:0] ALU_SUBU = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1000;
  localparam logic [3:0] ALU_SRL  = 4'b1001;
  localparam logic [3:0] ALU_ADD  = 4'b1011;
  localparam logic [3:0] ALU_SSUB = 4'b1100;
  localparam logic [3:0] ALU_IDLE = 4'b1111;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // Output side FSM: nothing shown, op shown, or forced idle gap
  typedef enum logic [1:0] {
    S_EMPTY   = 2'd0,
    S_PRESENT = 2'd1,
    S_BUBBLE  = 2'd2
  } issue_state_e;

  // One decoded op as held in the skid FIFO and the output registers
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        illegal;
  } issue_op_t;

  localparam int ISSUE_OP_W = $bits(issue_op_t);

  localparam issue_op_t ILLEGAL_OP = '{ctrl: ALU_IDLE, op0: 32'd0, op1: 32'd0, illegal: 1'b1};

  // Turn the decoded instruction fields into an ALU code plus operands.
  // Unsupported encodings become an IDLE op flagged illegal so they still
  // flow through the pipeline in order.
  function automatic issue_op_t aluDecode(input logic [5:0]  opcode,
                                          input logic [5:0]  funct,
                                          input logic [4:0]  shamt,
                                          input logic [31:0] rsData,
                                          input logic [31:0] rtData,
                                          input logic [15:0] imm);
    issue_op_t   d;
    logic [31:0] immSext;
    logic [31:0] immZext;
    immSext = {{16{imm[15]}}, imm};
    immZext = {16'd0, imm};
    d = ILLEGAL_OP;
    case (opcode)
      OP_RTYPE: begin
        d.op0     = rsData;
        d.op1     = rtData;
        d.illegal = 1'b0;
        case (funct)
          FN_ADD:  d.ctrl = ALU_ADD;
          FN_ADDU: d.ctrl = ALU_ADDU;
          FN_SUB:  d.ctrl = ALU_SSUB;
          FN_SUBU: d.ctrl = ALU_SUBU;
          FN_AND:  d.ctrl = ALU_AND;
          FN_OR:   d.ctrl = ALU_OR;
          FN_XOR:  d.ctrl = ALU_XOR;
          FN_NOR:  d.ctrl = ALU_NOR;
          FN_SLT:  d.ctrl = ALU_SLT;
          FN_SLL: begin
            d.ctrl = ALU_SLL;
            d.op0  = rtData;
            d.op1  = {27'd0, shamt};
          end
          FN_SRL: begin
            d.ctrl = ALU_SRL;
            d.op0  = rtData;
            d.op1  = {27'd0, shamt};
          end
          default: d = ILLEGAL_OP;
        endcase
      end
      OP_ADDI:  d = '{ctrl: ALU_ADD,  op0: rsData, op1: immSext, illegal: 1'b0};
      OP_ADDIU: d = '{ctrl: ALU_ADDU, op0: rsData, op1: immSext, illegal: 1'b0};
      OP_SLTI:  d = '{ctrl: ALU_SLT,  op0: rsData, op1: immSext, illegal: 1'b0};
      OP_ANDI:  d = '{ctrl: ALU_AND,  op0: rsData, op1: immZext, illegal: 1'b0};
      OP_ORI:   d = '{ctrl: ALU_OR,   op0: rsData, op1: immZext, illegal: 1'b0};
      OP_XORI:  d = '{ctrl: ALU_XOR,  op0: rsData, op1: immZext, illegal: 1'b0};
      OP_BEQ:   d = '{ctrl: ALU_SUBU, op0: rsData, op1: rtData,  illegal: 1'b0};
      OP_LW,
      OP_SW:    d = '{ctrl: ALU_ADDU, op0: rsData, op1: immSext, illegal: 1'b0};
      default:  d = ILLEGAL_OP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_issue_fifo.sv
// Small synchronous FIFO used as the input skid buffer of the issue stage.
// DEPTH must be a power of two so the pointers wrap by plain overflow.
module alu_issue_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 69
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       data_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   full_o,
  output logic                   empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign data_o  = mem_q[rdPtr_q];

  // Advance pointers and occupancy; a push and pop together leave count alone
  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (doPush) wrPtr_d = wrPtr_q + 1'b1;
    if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers; reset discards everything buffered
  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage array; stale contents are harmless once count is cleared
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes MIPS fields into ALU control/operands, buffers
// them in a small skid FIFO and presents them to the ALU with valid/ready.
// Because the ALU only recomputes when its control code changes, two
// consecutive ops with the same code are separated by one IDLE cycle.
module alu_issue
  import alu_pkg::*;
#(
  parameter bit BUBBLE_EN = 1'b1,
  parameter int DEPTH     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [4:0]  shamt,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic [15:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  control,
  output logic [31:0] operand0,
  output logic [31:0] operand1,
  output logic        illegal
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  issue_op_t              inOp;
  issue_op_t              headOp;
  logic [ISSUE_OP_W-1:0]  headBits;
  logic [CNT_W-1:0]       fifoCount;
  logic                   fifoFull;
  logic                   fifoEmpty;
  logic                   pushEn;
  logic                   popEn;
  logic                   loadHead;
  logic                   headMatch;

  issue_state_e state_q, state_d;
  logic [3:0]   ctrl_q, ctrl_d;
  logic [31:0]  op0_q, op0_d;
  logic [31:0]  op1_q, op1_d;
  logic         illegal_q, illegal_d;
  logic [3:0]   lastCtrl_q, lastCtrl_d;
  logic         lastValid_q, lastValid_d;

  assign inOp     = aluDecode(opcode, funct, shamt, rs_data, rt_data, imm);
  assign in_ready = (fifoCount < CNT_W'(DEPTH));
  assign pushEn   = in_valid && !fifoFull;
  assign headOp   = headBits;

  alu_issue_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ISSUE_OP_W)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (pushEn),
    .pop_i   (popEn),
    .data_i  (inOp),
    .data_o  (headBits),
    .count_o (fifoCount),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  // A bubble is needed when the next op repeats the code last shown to the ALU
  assign headMatch = BUBBLE_EN && lastValid_q && (headOp.ctrl == lastCtrl_q);

  // Output FSM next state: decide between presenting the head, idling or bubbling
  always_comb begin
    state_d     = state_q;
    ctrl_d      = ctrl_q;
    op0_d       = op0_q;
    op1_d       = op1_q;
    illegal_d   = illegal_q;
    lastCtrl_d  = lastCtrl_q;
    lastValid_d = lastValid_q;
    popEn       = 1'b0;
    loadHead    = 1'b0;
    unique case (state_q)
      S_EMPTY: begin
        if (!fifoEmpty) begin
          if (headMatch) begin
            state_d = S_BUBBLE;
            ctrl_d  = ALU_IDLE;
          end else begin
            loadHead = 1'b1;
          end
        end
      end
      S_PRESENT: begin
        if (out_ready) begin
          if (fifoEmpty) begin
            state_d = S_EMPTY;
          end else if (headMatch) begin
            state_d = S_BUBBLE;
            ctrl_d  = ALU_IDLE;
          end else begin
            loadHead = 1'b1;
          end
        end
      end
      S_BUBBLE: begin
        loadHead = 1'b1;
      end
      default: begin
        state_d = S_EMPTY;
      end
    endcase
    if (loadHead) begin
      popEn       = 1'b1;
      state_d     = S_PRESENT;
      ctrl_d      = headOp.ctrl;
      op0_d       = headOp.op0;
      op1_d       = headOp.op1;
      illegal_d   = headOp.illegal;
      lastCtrl_d  = headOp.ctrl;
      lastValid_d = 1'b1;
    end
  end

  // Output registers and FSM state; reset returns to an idle, empty stage
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_EMPTY;
      ctrl_q      <= ALU_IDLE;
      op0_q       <= '0;
      op1_q       <= '0;
      illegal_q   <= 1'b0;
      lastCtrl_q  <= ALU_IDLE;
      lastValid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ctrl_q      <= ctrl_d;
      op0_q       <= op0_d;
      op1_q       <= op1_d;
      illegal_q   <= illegal_d;
      lastCtrl_q  <= lastCtrl_d;
      lastValid_q <= lastValid_d;
    end
  end

  assign out_valid = (state_q == S_PRESENT);
  assign control   = ctrl_q;
  assign operand0  = op0_q;
  assign operand1  = op1_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed cycle-exact steps followed by
// a randomized phase scored against a transaction-level reference model.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        inValid;
  logic        inReady;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] rsData;
  logic [31:0] rtData;
  logic [15:0] imm;
  logic        outValid;
  logic        outReady;
  logic [3:0]  control;
  logic [31:0] operand0;
  logic [31:0] operand1;
  logic        illegal;

  logic        inReady2;
  logic        outValid2;
  logic [3:0]  control2;
  logic [31:0] operand0b;
  logic [31:0] operand1b;
  logic        illegal2;

  int compared   = 0;
  int mismatched = 0;

  alu_issue #(.BUBBLE_EN(1'b1), .DEPTH(2)) dut (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rs_data(rsData),
    .rt_data(rtData), .imm(imm), .out_valid(outValid), .out_ready(outReady),
    .control(control), .operand0(operand0), .operand1(operand1), .illegal(illegal)
  );

  alu_issue #(.BUBBLE_EN(1'b0), .DEPTH(2)) dutNoBubble (
    .clk(clk), .reset(reset), .in_valid(inValid), .in_ready(inReady2),
    .opcode(opcode), .funct(funct), .shamt(shamt), .rs_data(rsData),
    .rt_data(rtData), .imm(imm), .out_valid(outValid2), .out_ready(outReady),
    .control(control2), .operand0(operand0b), .operand1(operand1b), .illegal(illegal2)
  );

  always #5 clk = ~clk;

  // Expected op as the ALU should see it
  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] op0;
    logic [31:0] op1;
    logic        illegal;
  } refOp_t;

  function automatic refOp_t mk(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    refOp_t r;
    r.ctrl = c; r.op0 = a; r.op1 = b; r.illegal = 1'b0;
    return r;
  endfunction

  // Reference decode written straight from the instruction table
  function automatic refOp_t refDecode(input logic [5:0] opc, input logic [5:0] fn,
                                       input logic [4:0] sh, input logic [31:0] rs,
                                       input logic [31:0] rt, input logic [15:0] im);
    refOp_t r;
    logic [31:0] se;
    logic [31:0] ze;
    se = {{16{im[15]}}, im};
    ze = {16'd0, im};
    r.ctrl = 4'b1111; r.op0 = 32'd0; r.op1 = 32'd0; r.illegal = 1'b1;
    if (opc == 6'b000000) begin
      case (fn)
        6'b100000: r = mk(4'b1011, rs, rt);
        6'b100001: r = mk(4'b0010, rs, rt);
        6'b100010: r = mk(4'b1100, rs, rt);
        6'b100011: r = mk(4'b0110, rs, rt);
        6'b100100: r = mk(4'b0000, rs, rt);
        6'b100101: r = mk(4'b0001, rs, rt);
        6'b100110: r = mk(4'b0011, rs, rt);
        6'b100111: r = mk(4'b0100, rs, rt);
        6'b101010: r = mk(4'b0111, rs, rt);
        6'b000000: r = mk(4'b1000, rt, {27'd0, sh});
        6'b000010: r = mk(4'b1001, rt, {27'd0, sh});
        default: ;
      endcase
    end else begin
      case (opc)
        6'b001000: r = mk(4'b1011, rs, se);
        6'b001001: r = mk(4'b0010, rs, se);
        6'b001010: r = mk(4'b0111, rs, se);
        6'b001100: r = mk(4'b0000, rs, ze);
        6'b001101: r = mk(4'b0001, rs, ze);
        6'b001110: r = mk(4'b0011, rs, ze);
        6'b000100: r = mk(4'b0110, rs, rt);
        6'b100011: r = mk(4'b0010, rs, se);
        6'b101011: r = mk(4'b0010, rs, se);
        default: ;
      endcase
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [71:0] observed, input logic [71:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                               input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] im,
                               input logic valid);
    opcode = opc; funct = fn; shamt = sh; rsData = rs; rtData = rt; imm = im; inValid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic randomOp();
    int k;
    logic [5:0] opc;
    logic [5:0] fn;
    k = $urandom_range(0, 13);
    opc = 6'b000000;
    fn  = 6'($urandom_range(0, 63));
    case (k)
      0:  fn  = 6'b100000;
      1:  fn  = 6'b100010;
      2:  fn  = 6'b101010;
      3:  fn  = 6'b000000;
      4:  fn  = 6'b000010;
      5:  opc = 6'b001001;
      6:  opc = 6'b001101;
      7:  opc = 6'b001000;
      8:  opc = 6'b000100;
      9:  opc = 6'b100011;
      10: opc = 6'b101011;
      11: opc = 6'b001110;
      12: opc = 6'($urandom_range(0, 63));
      default: opc = 6'b111111;
    endcase
    applyStimulus(opc, fn, 5'($urandom), $urandom, $urandom, 16'($urandom),
                  ($urandom_range(0, 9) < 7));
  endtask

  // Transaction scoreboard: order/contents, hold stability, bubble spacing
  refOp_t      expQ[$];
  bit          sbOn = 1'b0;
  int          cyc = 0;
  bit          holdPend = 1'b0;
  logic [68:0] holdSnap;
  bit          haveXfer = 1'b0;
  int          lastXferCyc = 0;
  logic [3:0]  lastXferCtrl;

  always @(negedge clk) begin
    refOp_t e;
    cyc++;
    if (reset) begin
      expQ.delete();
      holdPend = 1'b0;
      haveXfer = 1'b0;
    end else if (sbOn) begin
      if (holdPend)
        checkOutput("hold", {outValid, control, operand0, operand1, illegal}, {1'b1, holdSnap});
      holdPend = outValid && !outReady;
      holdSnap = {control, operand0, operand1, illegal};
      if (outValid && outReady) begin
        checkOutput("issueQueued", 72'(expQ.size() != 0), 72'd1);
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkOutput("issueOp", {control, operand0, operand1, illegal},
                      {e.ctrl, e.op0, e.op1, e.illegal});
        end
        if (haveXfer && lastXferCtrl == control)
          checkOutput("bubbleGap", 72'((cyc - lastXferCyc) >= 2), 72'd1);
        haveXfer = 1'b1;
        lastXferCyc = cyc;
        lastXferCtrl = control;
      end
      if (inValid && inReady)
        expQ.push_back(refDecode(opcode, funct, shamt, rsData, rtData, imm));
    end
  end

  initial begin
    int n;
    reset = 1'b1; outReady = 1'b0;
    applyStimulus(6'd0, 6'd0, 5'd0, 32'd0, 32'd0, 16'd0, 1'b0);
    step(); step();
    reset = 1'b0; sbOn = 1'b1;
    $display("[TB] reset state");
    checkOutput("rstValid", 72'(outValid), 72'd0);
    checkOutput("rstCtrl", 72'(control), 72'hF);
    checkOutput("rstOp0", 72'(operand0), 72'd0);
    checkOutput("rstOp1", 72'(operand1), 72'd0);
    checkOutput("rstIllegal", 72'(illegal), 72'd0);
    checkOutput("rstInReady", 72'(inReady), 72'd1);

    $display("[TB] add then ori");
    outReady = 1'b1;
    applyStimulus(6'b000000, 6'b100000, 5'd0, 32'd5, 32'd7, 16'd0, 1'b1); step();
    applyStimulus(6'b001101, 6'd0, 5'd0, 32'h11, 32'd0, 16'h8000, 1'b1); step();
    checkOutput("addValid", 72'(outValid), 72'd1);
    checkOutput("addCtrl", 72'(control), 72'hB);
    checkOutput("addOp0", 72'(operand0), 72'd5);
    checkOutput("addOp1", 72'(operand1), 72'd7);
    inValid = 1'b0; step();
    checkOutput("oriCtrl", 72'(control), 72'h1);
    checkOutput("oriOp0", 72'(operand0), 72'h11);
    checkOutput("oriOp1", 72'(operand1), 72'h8000);
    step(); step();

    $display("[TB] addiu twice");
    applyStimulus(6'b001001, 6'd0, 5'd0, 32'd3, 32'd0, 16'hFFFF, 1'b1); step();
    applyStimulus(6'b001001, 6'd0, 5'd0, 32'd9, 32'd0, 16'hFFFF, 1'b1); step();
    checkOutput("addiu1Ctrl", 72'(control), 72'h2);
    checkOutput("addiu1Op1", 72'(operand1), 72'hFFFFFFFF);
    checkOutput("nbAddiu1Ctrl", 72'(control2), 72'h2);
    inValid = 1'b0; step();
    checkOutput("bubbleValid", 72'(outValid), 72'd0);
    checkOutput("bubbleCtrl", 72'(control), 72'hF);
    checkOutput("nbNoBubbleValid", 72'(outValid2), 72'd1);
    checkOutput("nbNoBubbleOp0", 72'(operand0b), 72'd9);
    step();
    checkOutput("addiu2Valid", 72'(outValid), 72'd1);
    checkOutput("addiu2Ctrl", 72'(control), 72'h2);
    checkOutput("addiu2Op0", 72'(operand0), 72'd9);
    step();
    applyStimulus(6'b001001, 6'd0, 5'd0, 32'd4, 32'd0, 16'h0001, 1'b1); step();
    inValid = 1'b0;
    checkOutput("emptyHoldCtrl", 72'({outValid, control}), 72'h02);
    step();
    checkOutput("emptyBubble", 72'({outValid, control}), 72'h0F);
    checkOutput("nbEmptyNoBubble", 72'({outValid2, control2}), 72'h12);
    step();
    checkOutput("afterEmptyBubble", 72'({outValid, control, operand0}), {40'd0, 1'b1, 4'h2, 32'd4} >> 0);
    step();

    $display("[TB] sll");
    applyStimulus(6'b000000, 6'b000000, 5'd4, 32'hABCD, 32'd1, 16'd0, 1'b1); step();
    inValid = 1'b0; step();
    checkOutput("sllCtrl", 72'(control), 72'h8);
    checkOutput("sllOp0", 72'(operand0), 72'd1);
    checkOutput("sllOp1", 72'(operand1), 72'd4);
    step();

    $display("[TB] backpressure");
    outReady = 1'b0;
    applyStimulus(6'b000000, 6'b100100, 5'd0, 32'd1, 32'd2, 16'd0, 1'b1); step();
    applyStimulus(6'b000000, 6'b100101, 5'd0, 32'd3, 32'd4, 16'd0, 1'b1); step();
    applyStimulus(6'b000000, 6'b100110, 5'd0, 32'd5, 32'd6, 16'd0, 1'b1); step();
    inValid = 1'b0;
    checkOutput("bpInReady", 72'(inReady), 72'd0);
    checkOutput("bpHead", 72'({outValid, control, operand0}), {35'd0, 1'b1, 4'h0, 32'd1});
    step(); step();
    checkOutput("bpStable", 72'({outValid, control, operand0, operand1}), {3'd0, 1'b1, 4'h0, 32'd1, 32'd2});
    outReady = 1'b1; step();
    checkOutput("bpSecond", 72'({control, operand0}), {36'd0, 4'h1, 32'd3});
    checkOutput("bpInReadyBack", 72'(inReady), 72'd1);
    step();
    checkOutput("bpThird", 72'({control, operand0}), {36'd0, 4'h3, 32'd5});
    step();

    $display("[TB] illegal then and");
    applyStimulus(6'b111111, 6'd0, 5'd0, 32'd77, 32'd88, 16'h1234, 1'b1); step();
    applyStimulus(6'b000000, 6'b100100, 5'd0, 32'd8, 32'd9, 16'd0, 1'b1); step();
    checkOutput("illegalOp", 72'({outValid, control, illegal, operand0}), {34'd0, 1'b1, 4'hF, 1'b1, 32'd0});
    inValid = 1'b0; step();
    checkOutput("andAfterIllegal", 72'({outValid, control, illegal, operand0}), {34'd0, 1'b1, 4'h0, 1'b0, 32'd8});
    step();

    $display("[TB] reset mid-stream");
    outReady = 1'b0;
    applyStimulus(6'b000000, 6'b100000, 5'd0, 32'd1, 32'd1, 16'd0, 1'b1); step();
    applyStimulus(6'b000000, 6'b100010, 5'd0, 32'd2, 32'd2, 16'd0, 1'b1); step();
    applyStimulus(6'b000000, 6'b100101, 5'd0, 32'd3, 32'd3, 16'd0, 1'b1); step();
    inValid = 1'b0; reset = 1'b1;
    step(); step();
    checkOutput("midRstState", 72'({outValid, control, inReady, illegal, operand0}),
                {33'd0, 1'b0, 4'hF, 1'b1, 1'b0, 32'd0});
    reset = 1'b0; outReady = 1'b1; step();
    checkOutput("midRstNoIssue", 72'(outValid), 72'd0);

    $display("[TB] random phase");
    for (int i = 0; i < 400; i++) begin
      randomOp();
      outReady = ($urandom_range(0, 3) != 0);
      step();
    end
    inValid = 1'b0; outReady = 1'b1;
    n = 0;
    while ((expQ.size() != 0 || outValid) && n < 50) begin
      step();
      n++;
    end
    checkOutput("drainDone", 72'(expQ.size()), 72'd0);
    checkOutput("drainIdle", 72'(outValid), 72'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
